// File: rtl/wb_sequencer.sv
// wb_sequencer: write-back sequencer for the processor core.
// Accepts one decoded instruction at a time, drives the write-back mux
// select, the register-file write strobe and the data-memory handshake.
// A data-memory access stalls the PC until dm_ready arrives, and an
// access that never completes within TIMEOUT cycles parks the block in a
// sticky error state that only reset clears.
module wb_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [1:0] wb_src,
    input  logic       is_load,
    input  logic       is_store,
    input  logic [4:0] rd,
    input  logic       dm_ready,
    output logic [1:0] MUXdm_alu_sumop,
    output logic       ru_wr,
    output logic [4:0] ru_rd,
    output logic       dm_req,
    output logic       dm_we,
    output logic       pc_stall,
    output logic       err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [1:0] SEL_DM  = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_SUM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [4:0]       r_rd;
    logic             r_wr;
    logic             r_req;
    logic             r_we;
    logic             r_stall;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_memRd;
    logic             r_memLoad;

    logic [1:0]       w_state;
    logic [1:0]       w_sel;
    logic [4:0]       w_rd;
    logic             w_wr;
    logic             w_req;
    logic             w_we;
    logic             w_stall;
    logic             w_err;
    logic [CNT_W-1:0] w_cnt;
    logic [4:0]       w_memRd;
    logic             w_memLoad;

    logic             w_accept;
    logic             w_memOp;
    logic             w_regWrite;

    // An instruction is taken only while the PC is not held; memory ops take priority over register writes
    always_comb begin
        w_accept   = instr_valid & ~r_stall;
        w_memOp    = is_load | is_store;
        w_regWrite = ((wb_src == SEL_ALU) || (wb_src == SEL_SUM)) && (rd != 5'd0);
    end

    // Next-value computation for every registered output; ru_wr is a single-cycle strobe so it defaults low
    always_comb begin
        w_state   = r_state;
        w_sel     = r_sel;
        w_rd      = r_rd;
        w_wr      = 1'b0;
        w_req     = r_req;
        w_we      = r_we;
        w_stall   = r_stall;
        w_err     = r_err;
        w_cnt     = r_cnt;
        w_memRd   = r_memRd;
        w_memLoad = r_memLoad;

        case (r_state)
            IDLE, WB: begin
                w_state = IDLE;
                w_req   = 1'b0;
                w_stall = 1'b0;
                if (w_accept && w_memOp) begin
                    w_state   = MEM;
                    w_req     = 1'b1;
                    w_we      = ~is_load;
                    w_memRd   = rd;
                    w_memLoad = is_load;
                    w_cnt     = '0;
                    w_stall   = 1'b1;
                end else if (w_accept && w_regWrite) begin
                    w_state = WB;
                    w_sel   = wb_src;
                    w_rd    = rd;
                    w_wr    = 1'b1;
                end
            end
            MEM: begin
                if (dm_ready) begin
                    w_req   = 1'b0;
                    w_stall = 1'b0;
                    if (r_memLoad && (r_memRd != 5'd0)) begin
                        w_state = WB;
                        w_sel   = SEL_DM;
                        w_rd    = r_memRd;
                        w_wr    = 1'b1;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state = ERR;
                    w_req   = 1'b0;
                    w_err   = 1'b1;
                    w_stall = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            ERR: begin
                w_state = ERR;
                w_req   = 1'b0;
                w_stall = 1'b1;
                w_err   = 1'b1;
            end
            default: begin
                w_state = IDLE;
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= SEL_ALU;
            r_rd      <= 5'd0;
            r_wr      <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_stall   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_memRd   <= 5'd0;
            r_memLoad <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_sel     <= w_sel;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            r_req     <= w_req;
            r_we      <= w_we;
            r_stall   <= w_stall;
            r_err     <= w_err;
            r_cnt     <= w_cnt;
            r_memRd   <= w_memRd;
            r_memLoad <= w_memLoad;
        end
    end

    assign MUXdm_alu_sumop = r_sel;
    assign ru_wr           = r_wr;
    assign ru_rd           = r_rd;
    assign dm_req          = r_req;
    assign dm_we           = r_we;
    assign pc_stall        = r_stall;
    assign err             = r_err;

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the processor core. Accepts one decoded instruction at a time and drives the write-back source select `MUXdm_alu_sumop`. It also drives the register-file write enable and the data-memory request handshake. Variable-latency data memory stalls the PC until the access completes, and a bounded wait flags a sticky error.

## Interface
- `TIMEOUT`, 16: maximum cycles spent waiting for `dm_ready` per access; legal range 2..256.
- `CNT_W`, 8: wait-counter width; must satisfy 2^CNT_W ≥ TIMEOUT.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: decoded instruction present this cycle.
- `wb_src` in 2: 01 = ALU result, 10 = PC+4, 11 = no write-back; 00 is treated as 11 unless `is_load`.
- `is_load` in 1: instruction is a load; write-back source forced to data memory.
- `is_store` in 1: instruction is a store; no write-back.
- `rd` in 5: destination register.
- `dm_ready` in 1: data memory completes the current access.
- `MUXdm_alu_sumop` out 2: write-back mux select (00 dm, 01 alu, 10 sum); 11 is never driven.
- `ru_wr` out 1: register-file write enable, one-cycle pulse.
- `ru_rd` out 5: register-file write address.
- `dm_req` out 1: data-memory request, held until `dm_ready`.
- `dm_we` out 1: 1 = store, 0 = load; valid while `dm_req`.
- `pc_stall` out 1: 1 = instruction not accepted; hold PC.
- `err` out 1: sticky memory timeout.

## Operation
- States: IDLE, MEM, WB, ERR. All outputs are registered.
- Accept condition: `instr_valid & ~pc_stall`. Acceptance is legal in IDLE and WB.
- On accept with `is_load` or `is_store`:
  - go to MEM;
  - `dm_req`=1, `dm_we`=`is_store`;
  - capture `rd`;
  - clear the wait counter.
  - If both flags are set, `is_load` wins.
- On accept with `wb_src` ∈ {01, 10} and `rd`≠0: go to WB with select = `wb_src` and `ru_rd` = `rd`.
- Otherwise (`wb_src` 00/11, or `rd`=0, or no accept): go to or stay in IDLE with no write.
- MEM behaviour:
  - `dm_req` stays high and the counter increments each cycle.
  - On `dm_ready`, a load with `rd`≠0 goes to WB with select 00, and `dm_req` drops.
  - On `dm_ready`, a store or a load to x0 goes to IDLE.
  - With counter = TIMEOUT-1 and no `dm_ready`, go to ERR with `dm_req`=0 and `err`=1.
- WB: `ru_wr`=1 for exactly this cycle. The next state follows the accept rules, else IDLE.
- ERR: `pc_stall`=1, `ru_wr`=0, `dm_req`=0. Only reset exits this state.
- `MUXdm_alu_sumop` and `ru_rd` keep their last value outside WB.
- `pc_stall`=1 in MEM and ERR, 0 otherwise.

## Timing
- Reset values:
  - state IDLE;
  - `MUXdm_alu_sumop`=01, `ru_rd`=0;
  - `ru_wr`, `dm_req`, `dm_we`, `pc_stall`, `err` all 0;
  - counter 0.
- ALU/PC+4 instruction accepted at edge N: `ru_wr` is high in cycle N+1. Back-to-back accepts give one write per cycle.
- Load accepted at N:
  - `dm_req` rises in cycle N+1.
  - `dm_ready` in the first MEM cycle (N+1) gives `ru_wr` in N+2.
  - Each extra wait cycle adds one cycle of latency.
- `dm_ready` is ignored outside MEM.
- `dm_ready` on the TIMEOUT-th MEM cycle counts as success; there is no error.
- Reset asserted mid-MEM: the access is abandoned. All outputs take reset values after the edge, with no `ru_wr` pulse.
- `instr_valid` while `pc_stall`=1: ignored. Upstream must hold the instruction.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles → all outputs at reset values. ALU op with `rd`=5 accepted at N → `ru_wr`=1, `ru_rd`=5, `MUXdm_alu_sumop`=01 in N+1 only.
- Load to `rd`=7 with `dm_ready` 3 cycles after `dm_req` rises:
  - `pc_stall` and `dm_req` high for 3 cycles, `dm_we`=0;
  - then `ru_wr`=1 with select 00 and `ru_rd`=7 for one cycle;
  - `pc_stall` is 0 in that cycle.
- Store, then JAL (`wb_src`=10, `rd`=1), then ALU op (`rd`=2) back-to-back:
  - the store gives no `ru_wr`, with `dm_we`=1;
  - the following writes occur in consecutive cycles with selects 10 then 01.
- Load with `dm_ready` never asserted, TIMEOUT=16 → after exactly 16 MEM cycles, `err`=1, `dm_req`=0, and `pc_stall` stuck at 1. Reset then clears it.
- Load with `dm_ready` on the 16th MEM cycle → normal write-back and `err`=0.
- Boundary cases:
  - ALU op with `rd`=0 → no `ru_wr`.
  - `wb_src`=11 → no write.
  - `rst_n` low during MEM → IDLE with no write-back pulse.
